// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier: one recoding step per clock.
// A WIDTH+1 accumulator keeps the 2*WIDTH-bit signed product exact for every operand pair.
module seq_booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  // state | meaning
  // ----- | ---------------------------------------------
  // IDLE  | ready=1, waiting for start
  // RUN   | one Booth step per clock, WIDTH steps in total
  // DONE  | done=1 for one cycle, product valid
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mq_nxt;
  logic             q_1;
  logic [CNT_W-1:0] cnt;

  // Add/subtract chosen by the Booth pair, then arithmetic shift of {acc, mq, q_1}.
  always_comb begin
    case ({mq[0], q_1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    mq_nxt  = {sum[0], mq[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mq      <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            mq    <= multiplier;
            q_1   <= 1'b0;
            mcand <= {multiplicand[WIDTH-1], multiplicand};
            cnt   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          mq  <= mq_nxt;
          q_1 <= mq[0];
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            product <= {acc_nxt[WIDTH-1:0], mq_nxt};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
